// File: rtl/alu_issue_if.sv
// Handshake bundle between the decode/issue stage and its neighbours.
//   in_*      : instruction word + rs1/rs2 values, valid/ready from upstream
//   out_*/alu*: decoded ALU op, operands, rd, illegal flag, valid/ready to ALU
//   issue_count: running count of completed output handshakes
// slave  = the issue stage, master = upstream/downstream environment.
interface alu_issue_if #(
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [31:0]      in_rs1_val;
  logic [31:0]      in_rs2_val;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       alu_op;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [4:0]       alu_rd;
  logic             illegal;
  logic [CNT_W-1:0] issue_count;

  modport slave (
    input  in_valid, in_instr, in_rs1_val, in_rs2_val, out_ready,
    output in_ready, out_valid, alu_op, alu_a, alu_b, alu_rd, illegal, issue_count
  );

  modport master (
    output in_valid, in_instr, in_rs1_val, in_rs2_val, out_ready,
    input  in_ready, out_valid, alu_op, alu_a, alu_b, alu_rd, illegal, issue_count
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I OP / OP-IMM decode and issue stage feeding a 32-bit ALU.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : alu_issue_if.slave (input handshake + decoded output handshake)
// Decode is combinational on the input word; the result lands in a main
// output register backed by one skid entry, so in_ready is purely registered
// (= skid empty) while still sustaining one issue per cycle.
module alu_issue_stage #(
  parameter logic [5:0] ILLEGAL_OP = 6'h3F,
  parameter int         CNT_W      = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  alu_issue_if.slave  bus
);

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } entry_t;

  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] F7_Z    = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ---------------- decode ----------------
  entry_t     dec;
  logic [6:0] opc, f7;
  logic [2:0] f3;

  assign opc = bus.in_instr[6:0];
  assign f3  = bus.in_instr[14:12];
  assign f7  = bus.in_instr[31:25];

  always_comb begin
    dec.op  = ILLEGAL_OP;
    dec.ill = 1'b1;
    dec.a   = bus.in_rs1_val;
    dec.b   = bus.in_rs2_val;
    dec.rd  = bus.in_instr[11:7];
    if (opc == OPC_IMM) begin
      dec.b   = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
      dec.ill = 1'b0;
      case (f3)
        3'd0: dec.op = 6'd0;
        3'd2: dec.op = 6'd1;
        3'd3: dec.op = 6'd2;
        3'd4: dec.op = 6'd3;
        3'd6: dec.op = 6'd4;
        3'd7: dec.op = 6'd5;
        3'd1: begin
          dec.b = {27'b0, bus.in_instr[24:20]};
          if (f7 == F7_Z) dec.op = 6'd6;
          else            dec.ill = 1'b1;
        end
        default: begin // f3 = 5: SRLI / SRAI
          dec.b = {27'b0, bus.in_instr[24:20]};
          if      (f7 == F7_Z)   dec.op = 6'd7;
          else if (f7 == F7_ALT) dec.op = 6'd8;
          else                   dec.ill = 1'b1;
        end
      endcase
    end else if (opc == OPC_OP) begin
      if (f7 == F7_Z) begin
        dec.ill = 1'b0;
        case (f3)
          3'd0:    dec.op = 6'd9;
          3'd1:    dec.op = 6'd11;
          3'd2:    dec.op = 6'd12;
          3'd3:    dec.op = 6'd13;
          3'd4:    dec.op = 6'd14;
          3'd5:    dec.op = 6'd15;
          3'd6:    dec.op = 6'd17;
          default: dec.op = 6'd18;
        endcase
      end else if (f7 == F7_ALT && f3 == 3'd0) begin
        dec.ill = 1'b0;
        dec.op  = 6'd10;
      end else if (f7 == F7_ALT && f3 == 3'd5) begin
        dec.ill = 1'b0;
        dec.op  = 6'd16;
      end
    end
    // an illegal op always reports ILLEGAL_OP, whatever partial decode happened
    if (dec.ill) dec.op = ILLEGAL_OP;
  end

  // ---------------- main + skid registers ----------------
  entry_t           main_q, main_d, skid_q, skid_d;
  logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_xfer, out_xfer;

  assign in_xfer  = bus.in_valid & ~skid_vld_q;
  assign out_xfer = main_vld_q & bus.out_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q + CNT_W'(out_xfer);
    if (!main_vld_q || out_xfer) begin
      // skid holds the older op, so it always refills main first
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = in_xfer;
        if (in_xfer) main_d = dec;
      end
    end else if (in_xfer) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready    = ~skid_vld_q;
  assign bus.out_valid   = main_vld_q;
  assign bus.alu_op      = main_q.op;
  assign bus.alu_a       = main_q.a;
  assign bus.alu_b       = main_q.b;
  assign bus.alu_rd      = main_q.rd;
  assign bus.illegal     = main_q.ill;
  assign bus.issue_count = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_if #(.CNT_W(CW)) ifc ();

  alu_issue_stage #(.ILLEGAL_OP(6'h3F), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(ifc)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t   q[$];
  int     mcnt;
  int     total;
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decode straight from the RV32I tables.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    int   imm_tab[8] = '{0, -1, 1, 2, 3, -1, 4, 5};   // f3 -> op for non-shift OP-IMM
    int   r_tab[8]   = '{9, 11, 12, 13, 14, 15, 17, 18};
    int   f3 = int'(ins[14:12]);
    int   f7 = int'(ins[31:25]);
    int   op = -1;
    e.a  = r1;
    e.rd = ins[11:7];
    e.b  = r2;
    if (ins[6:0] == 7'h13) begin
      e.b = 32'($signed(ins[31:20]));
      if (f3 == 1) begin
        e.b = 32'(ins[24:20]);
        if (f7 == 0) op = 6;
      end else if (f3 == 5) begin
        e.b = 32'(ins[24:20]);
        if (f7 == 0) op = 7;
        else if (f7 == 32) op = 8;
      end else op = imm_tab[f3];
    end else if (ins[6:0] == 7'h33) begin
      if (f7 == 0) op = r_tab[f3];
      else if (f7 == 32 && f3 == 0) op = 10;
      else if (f7 == 32 && f3 == 5) op = 16;
    end
    e.ill = (op < 0);
    e.op  = (op < 0) ? 6'h3F : 6'(op);
    return e;
  endfunction

  // One clock of stimulus; checks the DUT state against the model before the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                      input logic [31:0] r2, input logic ordy, output logic acc);
    exp_t got;
    logic ix, ox;
    @(negedge clk);
    ifc.in_valid = v; ifc.in_instr = ins; ifc.in_rs1_val = r1; ifc.in_rs2_val = r2;
    ifc.out_ready = ordy;
    #1;
    chk("in_ready",  ifc.in_ready,  q.size() < 2);
    chk("out_valid", ifc.out_valid, q.size() > 0);
    chk("count",     ifc.issue_count, mcnt);
    if (q.size() > 0) begin
      got = {ifc.alu_op, ifc.alu_a, ifc.alu_b, ifc.alu_rd, ifc.illegal};
      chk("head", got, q[0]);
    end
    ix = v && (q.size() < 2);
    ox = ordy && (q.size() > 0);
    @(posedge clk);
    if (ox) begin
      void'(q.pop_front());
      mcnt = (mcnt + 1) % (1 << CW);
      total++;
    end
    if (ix) q.push_back(ref_dec(ins, r1, r2));
    acc = ix;
  endtask

  task automatic do_reset();
    ifc.in_valid = 0; ifc.out_ready = 0;
    ifc.in_instr = 0; ifc.in_rs1_val = 0; ifc.in_rs2_val = 0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    q.delete(); mcnt = 0; total = 0;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4)      w[6:0] = 7'h13;
    else if (k < 8) w[6:0] = 7'h33;
    k = $urandom_range(0, 9);
    if (k < 5)      w[31:25] = 7'h00;
    else if (k < 8) w[31:25] = 7'h20;
    return w;
  endfunction

  initial begin
    logic acc;
    int   idx, cyc;
    mcnt = 0; total = 0;

    // 1: reset state
    do_reset();
    #1;
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_in_ready",  ifc.in_ready,  1);
    chk("rst_count",     ifc.issue_count, 0);
    chk("rst_alu_op",    ifc.alu_op, 0);

    // 2: ADDI x5,x1,-1
    step(1, 32'hFFF08293, 32'd7, 32'd0, 1, acc);
    #1;
    chk("addi_op",  ifc.alu_op, 6'd0);
    chk("addi_a",   ifc.alu_a,  32'd7);
    chk("addi_b",   ifc.alu_b,  32'hFFFFFFFF);
    chk("addi_rd",  ifc.alu_rd, 5'd5);
    chk("addi_ill", ifc.illegal, 0);

    // 3: SUB, SRAI shamt 4, SRAI with bad funct7
    step(1, 32'h402081B3, 32'd9, 32'd3, 1, acc);
    #1;
    chk("sub_op", ifc.alu_op, 6'd10);
    step(1, 32'h4040D113, 32'd1, 32'd0, 1, acc);
    #1;
    chk("srai_op", ifc.alu_op, 6'd8);
    chk("srai_b",  ifc.alu_b,  32'd4);
    step(1, 32'h0240D113, 32'd1, 32'd0, 1, acc);
    #1;
    chk("srai_bad_op",  ifc.alu_op, 6'h3F);
    chk("srai_bad_ill", ifc.illegal, 1);
    step(0, 0, 0, 0, 1, acc);

    // 4: five back-to-back ops, consumer stalled for 3 cycles
    do_reset();
    idx = 0; cyc = 0;
    while ((idx < 5 || q.size() > 0) && cyc < 40) begin
      step(idx < 5, rnd_instr(), $urandom, $urandom, cyc >= 3, acc);
      if (acc) idx++;
      cyc++;
      if (cyc == 2) begin
        #1;
        chk("t4_in_ready_low", ifc.in_ready, 0);
      end
    end
    chk("t4_drained", q.size(), 0);
    #1;
    chk("t4_count", ifc.issue_count, 5);

    // 5: streaming, one issue per cycle
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, rnd_instr(), $urandom, $urandom, 1, acc);
      chk("t5_accept", acc, 1);
    end
    #1;
    chk("t5_count", ifc.issue_count, 19);

    // 6a: reset with both entries full
    step(0, 0, 0, 0, 1, acc);
    step(1, rnd_instr(), $urandom, $urandom, 0, acc);
    step(1, rnd_instr(), $urandom, $urandom, 0, acc);
    @(negedge clk);
    #1;
    chk("t6_full", ifc.in_ready, 0);
    reset_n = 0;
    #1;
    chk("t6_rst_out_valid", ifc.out_valid, 0);
    chk("t6_rst_in_ready",  ifc.in_ready,  1);
    chk("t6_rst_count",     ifc.issue_count, 0);
    do_reset();

    // 6b: random traffic, long enough for the 8-bit counter to wrap
    for (int i = 0; i < 900; i++)
      step($urandom_range(0, 9) < 8, rnd_instr(), $urandom, $urandom,
           $urandom_range(0, 9) < 7, acc);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, acc);
    #1;
    chk("wrap_seen", total > 256, 1);
    chk("wrap_count", ifc.issue_count, total % 256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
